// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared widths, handshake levels and entry type for the instruction queue
package inst_queue_pkg;

  localparam int DataLength = 31;
  localparam int PcLength   = 31;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef struct packed {
    logic [DataLength:0] inst;
    logic [PcLength:0]   pc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction queue between fetch and decode
// One push and one pop per cycle; flush from the ROB empties the queue.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int IqLength      = 15,
  parameter int PointerLength = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_empty_from_if,
  input  logic [DataLength:0] inst_from_if,
  input  logic [PcLength:0]   pc_from_if,
  input  logic                is_ready_from_rs,
  input  logic                is_ready_from_lsb,
  input  logic                is_exception_from_rob,
  output logic                is_ready_to_if,
  output logic [DataLength:0] inst_to_dc,
  output logic [PcLength:0]   pc_to_dc,
  output logic                is_empty_to_dc
);

  localparam int PtrW = PointerLength + 1;
  localparam int CntW = PointerLength + 2;

  localparam logic [CntW-1:0] DEPTH     = CntW'(IqLength + 1);
  localparam logic [CntW-1:0] READY_MAX = CntW'(IqLength - 1);
  localparam logic [CntW-1:0] CNT_ONE   = CntW'(1);
  localparam logic [PtrW-1:0] PTR_LAST  = PtrW'(IqLength);
  localparam logic [PtrW-1:0] PTR_ONE   = PtrW'(1);

  iq_entry_t       entry [0:IqLength];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] count;
  logic [CntW-1:0] count_next;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Pop only looks at the pre-edge count, so a freshly pushed entry waits a cycle.
  always_comb begin
    do_push    = (is_empty_from_if == False) && (count < DEPTH);
    do_pop     = (count != '0) && is_ready_from_rs && is_ready_from_lsb;
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !is_exception_from_rob && do_push) begin
      entry[tail] <= '{inst: inst_from_if, pc: pc_from_if};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      inst_to_dc     <= '0;
      pc_to_dc       <= '0;
      is_empty_to_dc <= True;
      is_ready_to_if <= 1'b1;
    end else if (is_exception_from_rob) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      inst_to_dc     <= '0;
      pc_to_dc       <= '0;
      is_empty_to_dc <= True;
      is_ready_to_if <= 1'b1;
    end else begin
      if (do_push) begin
        tail <= ptr_inc(tail);
      end
      if (do_pop) begin
        head           <= ptr_inc(head);
        inst_to_dc     <= entry[head].inst;
        pc_to_dc       <= entry[head].pc;
        is_empty_to_dc <= False;
      end else begin
        is_empty_to_dc <= True;
      end
      count <= count_next;
      // One slot of headroom covers the push already in flight from fetch.
      is_ready_to_if <= (count_next <= READY_MAX);
    end
  end

endmodule
